// File: rtl/case_3_prod_accum_if.sv
// Stream and block-control bundle between a job producer/consumer and the
// product accumulator: start/idle/done, product input stream, result output stream.
interface case_3_prod_accum_if #(
    parameter int DIN_WIDTH = 6,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) ();
    logic                 ap_start;
    logic                 ap_idle;
    logic                 ap_done;
    logic [CNT_WIDTH-1:0] trip_cnt;
    logic [DIN_WIDTH-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic [ACC_WIDTH-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 acc_ovf;

    modport master (
        output ap_start, trip_cnt, din, din_valid, dout_ready,
        input  ap_idle, ap_done, din_ready, dout, dout_valid, acc_ovf
    );

    modport slave (
        input  ap_start, trip_cnt, din, din_valid, dout_ready,
        output ap_idle, ap_done, din_ready, dout, dout_valid, acc_ovf
    );
endinterface

// File: rtl/case_3_prod_accum.sv
// Accumulates trip_cnt signed multiplier products into a wrapping accumulator and
// hands the sum out on a valid/ready port, with a sticky signed-overflow flag per job.
module case_3_prod_accum #(
    parameter int DIN_WIDTH = 6,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    case_3_prod_accum_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  trip_q, trip_d;
    logic                  ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0]  din_ext;
    logic [ACC_WIDTH-1:0]  sum;
    logic                  beat;
    logic                  last_beat;
    logic                  add_ovf;

    // Sign-extend the narrow product up to accumulator width.
    assign din_ext[DIN_WIDTH-1:0] = bus.din;
    generate
        for (genvar gi = DIN_WIDTH; gi < ACC_WIDTH; gi++) begin : g_sext
            assign din_ext[gi] = bus.din[DIN_WIDTH-1];
        end
    endgenerate

    assign sum       = acc_q + din_ext;
    assign beat      = (state_q == S_ACCUM) && bus.din_valid;
    assign last_beat = beat && (cnt_q == (trip_q - CNT_ONE));
    // Overflow: operands agree in sign, result disagrees.
    assign add_ovf   = (acc_q[ACC_WIDTH-1] == din_ext[ACC_WIDTH-1]) &&
                       (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            trip_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            trip_q  <= trip_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        trip_d  = trip_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ap_start) begin
                    trip_d  = bus.trip_cnt;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (bus.trip_cnt != CNT_ZERO) ? S_ACCUM : S_DONE;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_ONE;
                    if (add_ovf) begin
                        ovf_d = 1'b1;
                    end
                end
                if (last_beat) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.dout_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.ap_idle    = (state_q == S_IDLE);
        bus.din_ready  = (state_q == S_ACCUM);
        bus.dout_valid = (state_q == S_DONE);
        bus.ap_done    = (state_q == S_DONE) && bus.dout_ready;
        bus.dout       = acc_q;
        bus.acc_ovf    = ovf_q;
    end

endmodule

// File: tb/tb_case_3_prod_accum.sv
// Drives two accumulators (16-bit and 8-bit result) with identical random jobs and
// checks each result against an arithmetic model of wrapped signed summation.
module tb_case_3_prod_accum;

    logic       ap_clk = 1'b0;
    logic       ap_rst_n = 1'b0;
    logic       start_r = 1'b0;
    logic [7:0] trip_r = '0;
    logic [5:0] din_r = '0;
    logic       din_valid_r = 1'b0;
    logic       dout_ready_r = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    int job_vals[$];

    logic [15:0] obs_dout16;
    logic [7:0]  obs_dout8;
    logic        obs_ovf16, obs_ovf8, obs_v8;
    int          obs_lat, obs_first_ready, obs_done_cnt;
    bit          obs_ready_seen, obs_stable, obs_timeout, obs_idle_after;

    always #5 ap_clk = ~ap_clk;

    case_3_prod_accum_if #(.DIN_WIDTH(6), .ACC_WIDTH(16), .CNT_WIDTH(8)) bus16 ();
    case_3_prod_accum_if #(.DIN_WIDTH(6), .ACC_WIDTH(8),  .CNT_WIDTH(8)) bus8 ();

    assign bus16.ap_start   = start_r;
    assign bus16.trip_cnt   = trip_r;
    assign bus16.din        = din_r;
    assign bus16.din_valid  = din_valid_r;
    assign bus16.dout_ready = dout_ready_r;
    assign bus8.ap_start    = start_r;
    assign bus8.trip_cnt    = trip_r;
    assign bus8.din         = din_r;
    assign bus8.din_valid   = din_valid_r;
    assign bus8.dout_ready  = dout_ready_r;

    case_3_prod_accum #(.DIN_WIDTH(6), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut16 (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus16)
    );

    case_3_prod_accum #(.DIN_WIDTH(6), .ACC_WIDTH(8), .CNT_WIDTH(8)) dut8 (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus8)
    );

    // Reference: exact integer sum, overflow whenever the true partial sum leaves
    // the signed range of the given width, result wrapped modulo 2^w.
    function automatic void model(input int w, output logic [15:0] res, output bit ovf);
        longint acc, t, m, hi, lo;
        acc = 0;
        m   = longint'(1) << w;
        hi  = m / 2 - 1;
        lo  = -(m / 2);
        ovf = 1'b0;
        foreach (job_vals[i]) begin
            t = acc + job_vals[i];
            if (t > hi || t < lo) ovf = 1'b1;
            if (t > hi) t -= m;
            else if (t < lo) t += m;
            acc = t;
        end
        res = 16'(acc & (m - 1));
    endfunction

    // Runs one job from job_vals; on return we sit at the negedge of the cycle
    // following the result handshake.
    task automatic run_job(input int trip, input int gap, input int hold,
                           input bit hold_start, input bit skip_start);
        int vals[$];
        int cyc, last_beat, first_valid, gap_cnt, vcnt;
        bit fin;
        vals = job_vals;
        cyc = 0; last_beat = -1; first_valid = -1; gap_cnt = 0; vcnt = 0; fin = 0;
        obs_ready_seen = 0; obs_stable = 1; obs_done_cnt = 0; obs_first_ready = -1;
        obs_dout16 = 'x; obs_dout8 = 'x; obs_ovf16 = 'x; obs_ovf8 = 'x; obs_v8 = 0;
        if (!skip_start) begin
            @(posedge ap_clk); #1;
            start_r = 1'b1;
            trip_r  = 8'(trip);
            @(posedge ap_clk); #1;
        end
        start_r = hold_start;
        while (!fin && cyc < 3000) begin
            if (vals.size() > 0 && gap_cnt == 0) begin
                din_valid_r = 1'b1;
                din_r       = 6'(vals[0]);
            end else begin
                din_valid_r = 1'b0;
                din_r       = 6'($urandom);
            end
            dout_ready_r = (vcnt >= hold);
            @(negedge ap_clk);
            if (bus16.din_ready) begin
                obs_ready_seen = 1;
                if (obs_first_ready < 0) obs_first_ready = cyc;
            end
            if (din_valid_r && bus16.din_ready) begin
                void'(vals.pop_front());
                last_beat = cyc;
                gap_cnt   = gap;
            end else if (gap_cnt > 0) begin
                gap_cnt--;
            end
            if (bus16.dout_valid) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    obs_dout16  = bus16.dout;
                    obs_ovf16   = bus16.acc_ovf;
                end else if (bus16.dout !== obs_dout16 || bus16.acc_ovf !== obs_ovf16) begin
                    obs_stable = 0;
                end
                vcnt++;
                if (dout_ready_r) begin
                    obs_dout8 = bus8.dout;
                    obs_ovf8  = bus8.acc_ovf;
                    obs_v8    = bus8.dout_valid;
                    fin = 1;
                end
            end
            if (bus16.ap_done) obs_done_cnt++;
            cyc++;
            @(posedge ap_clk); #1;
        end
        obs_timeout    = !fin;
        obs_lat        = (last_beat >= 0) ? (first_valid - last_beat) : first_valid;
        obs_idle_after = bus16.ap_idle;
        din_valid_r    = 1'b0;
        dout_ready_r   = 1'b0;
        @(negedge ap_clk);
        if (bus16.ap_done) obs_done_cnt++;
    endtask

    task automatic test_reset;
        logic [15:0] e16;
        bit eo;
        #2;
        tests_run++; if (bus16.ap_idle !== 1'b1) begin tests_failed++; $display("FAIL rst_idle got %b want 1", bus16.ap_idle); end
        tests_run++; if (bus16.ap_done !== 1'b0) begin tests_failed++; $display("FAIL rst_done got %b want 0", bus16.ap_done); end
        tests_run++; if (bus16.din_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_din_ready got %b want 0", bus16.din_ready); end
        tests_run++; if (bus16.dout_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_dout_valid got %b want 0", bus16.dout_valid); end
        tests_run++; if (bus16.dout !== 16'h0) begin tests_failed++; $display("FAIL rst_dout got %h want 0000", bus16.dout); end
        tests_run++; if (bus16.acc_ovf !== 1'b0) begin tests_failed++; $display("FAIL rst_ovf got %b want 0", bus16.acc_ovf); end
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        // Abandon a trip-8 job after three accepted beats.
        @(posedge ap_clk); #1;
        start_r = 1'b1; trip_r = 8'd8;
        @(posedge ap_clk); #1;
        start_r = 1'b0; din_valid_r = 1'b1; din_r = 6'd31;
        repeat (3) begin @(posedge ap_clk); #1; end
        #2;
        ap_rst_n = 1'b0;
        #1;
        tests_run++; if (bus16.ap_idle !== 1'b1) begin tests_failed++; $display("FAIL midrst_idle got %b want 1", bus16.ap_idle); end
        tests_run++; if (bus16.dout_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_dout_valid got %b want 0", bus16.dout_valid); end
        tests_run++; if (bus16.din_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_din_ready got %b want 0", bus16.din_ready); end
        din_valid_r = 1'b0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        job_vals = '{7, -2, 3};
        model(16, e16, eo);
        run_job(3, 0, 0, 0, 0);
        $display("[TB] reset-recovery job trip=3 dout=%h", obs_dout16);
        tests_run++; if (obs_dout16 !== e16) begin tests_failed++; $display("FAIL postrst_dout got %h want %h", obs_dout16, e16); end
        tests_run++; if (obs_ovf16 !== eo) begin tests_failed++; $display("FAIL postrst_ovf got %b want %b", obs_ovf16, eo); end
    endtask

    task automatic test_basic_sum;
        job_vals = '{5, -3, 31, -32};
        run_job(4, 0, 0, 0, 0);
        $display("[TB] basic job trip=4 dout=%h ovf=%b lat=%0d", obs_dout16, obs_ovf16, obs_lat);
        tests_run++; if (obs_dout16 !== 16'h0001) begin tests_failed++; $display("FAIL basic_dout got %h want 0001", obs_dout16); end
        tests_run++; if (obs_ovf16 !== 1'b0) begin tests_failed++; $display("FAIL basic_ovf got %b want 0", obs_ovf16); end
        tests_run++; if (obs_lat != 1) begin tests_failed++; $display("FAIL basic_latency got %0d want 1", obs_lat); end
        tests_run++; if (obs_first_ready != 0) begin tests_failed++; $display("FAIL basic_start_to_ready got %0d want 0", obs_first_ready); end
        tests_run++; if (obs_done_cnt != 1) begin tests_failed++; $display("FAIL basic_done_count got %0d want 1", obs_done_cnt); end
        tests_run++; if (obs_idle_after !== 1'b1) begin tests_failed++; $display("FAIL basic_idle_after got %b want 1", obs_idle_after); end
        tests_run++; if (obs_timeout) begin tests_failed++; $display("FAIL basic_timeout got 1 want 0"); end
    endtask

    task automatic test_stall_backpressure;
        job_vals = '{-1, -1, -1};
        run_job(3, 2, 5, 0, 0);
        $display("[TB] stall job trip=3 dout=%h stable=%0d", obs_dout16, obs_stable);
        tests_run++; if (obs_dout16 !== 16'hFFFD) begin tests_failed++; $display("FAIL stall_dout got %h want fffd", obs_dout16); end
        tests_run++; if (!obs_stable) begin tests_failed++; $display("FAIL stall_stable got 0 want 1"); end
        tests_run++; if (obs_done_cnt != 1) begin tests_failed++; $display("FAIL stall_done_count got %0d want 1", obs_done_cnt); end
        tests_run++; if (obs_lat != 1) begin tests_failed++; $display("FAIL stall_latency got %0d want 1", obs_lat); end
        tests_run++; if (obs_dout8 !== 8'hFD) begin tests_failed++; $display("FAIL stall_dout8 got %h want fd", obs_dout8); end
    endtask

    task automatic test_zero_trip;
        job_vals = {};
        run_job(0, 0, 1, 0, 0);
        $display("[TB] zero-trip job dout=%h ready_seen=%0d", obs_dout16, obs_ready_seen);
        tests_run++; if (obs_ready_seen) begin tests_failed++; $display("FAIL zero_din_ready got 1 want 0"); end
        tests_run++; if (obs_dout16 !== 16'h0) begin tests_failed++; $display("FAIL zero_dout got %h want 0000", obs_dout16); end
        tests_run++; if (obs_lat != 0) begin tests_failed++; $display("FAIL zero_latency got %0d want 0", obs_lat); end
        tests_run++; if (obs_done_cnt != 1) begin tests_failed++; $display("FAIL zero_done_count got %0d want 1", obs_done_cnt); end
    endtask

    task automatic test_overflow;
        job_vals = '{31, 31, 31, 31, 31};
        run_job(5, 0, 0, 0, 0);
        $display("[TB] overflow job trip=5 dout8=%h ovf8=%b dout16=%h", obs_dout8, obs_ovf8, obs_dout16);
        tests_run++; if (obs_dout8 !== 8'h9B) begin tests_failed++; $display("FAIL ovf_dout8 got %h want 9b", obs_dout8); end
        tests_run++; if (obs_ovf8 !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag8 got %b want 1", obs_ovf8); end
        tests_run++; if (obs_dout16 !== 16'd155) begin tests_failed++; $display("FAIL ovf_dout16 got %h want 009b", obs_dout16); end
        tests_run++; if (obs_ovf16 !== 1'b0) begin tests_failed++; $display("FAIL ovf_flag16 got %b want 0", obs_ovf16); end
        job_vals = '{1};
        run_job(1, 0, 0, 0, 0);
        $display("[TB] post-overflow job trip=1 dout8=%h ovf8=%b", obs_dout8, obs_ovf8);
        tests_run++; if (obs_dout8 !== 8'h01) begin tests_failed++; $display("FAIL ovf_next_dout8 got %h want 01", obs_dout8); end
        tests_run++; if (obs_ovf8 !== 1'b0) begin tests_failed++; $display("FAIL ovf_next_flag8 got %b want 0", obs_ovf8); end
    endtask

    task automatic test_start_collision;
        job_vals = '{4, 4};
        run_job(2, 1, 3, 1, 0);
        $display("[TB] collision job1 trip=2 dout=%h done_cnt=%0d", obs_dout16, obs_done_cnt);
        tests_run++; if (obs_done_cnt != 1) begin tests_failed++; $display("FAIL coll_done_count got %0d want 1", obs_done_cnt); end
        tests_run++; if (obs_dout16 !== 16'h0008) begin tests_failed++; $display("FAIL coll_dout got %h want 0008", obs_dout16); end
        tests_run++; if (bus16.ap_idle !== 1'b1) begin tests_failed++; $display("FAIL coll_idle got %b want 1", bus16.ap_idle); end
        // ap_start is still high: the new job is taken at the next edge.
        @(posedge ap_clk); #1;
        job_vals = '{-5, 9};
        run_job(2, 0, 0, 0, 1);
        $display("[TB] collision job2 trip=2 dout=%h first_ready=%0d", obs_dout16, obs_first_ready);
        tests_run++; if (obs_first_ready != 0) begin tests_failed++; $display("FAIL coll_restart got %0d want 0", obs_first_ready); end
        tests_run++; if (obs_dout16 !== 16'h0004) begin tests_failed++; $display("FAIL coll_dout2 got %h want 0004", obs_dout16); end
    endtask

    task automatic test_random;
        logic [15:0] e16, e8;
        bit eo16, eo8;
        int trip;
        for (int n = 0; n < 20; n++) begin
            trip = (n == 0) ? 255 : int'($urandom_range(0, 12));
            job_vals = {};
            for (int k = 0; k < trip; k++) job_vals.push_back(int'($urandom_range(0, 63)) - 32);
            model(16, e16, eo16);
            model(8, e8, eo8);
            run_job(trip, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0, 0);
            $display("[TB] random job %0d trip=%0d dout16=%h ovf16=%b dout8=%h ovf8=%b", n, trip, obs_dout16, obs_ovf16, obs_dout8, obs_ovf8);
            tests_run++; if (obs_dout16 !== e16) begin tests_failed++; $display("FAIL rand_dout16 job %0d got %h want %h", n, obs_dout16, e16); end
            tests_run++; if (obs_ovf16 !== eo16) begin tests_failed++; $display("FAIL rand_ovf16 job %0d got %b want %b", n, obs_ovf16, eo16); end
            tests_run++; if (obs_dout8 !== e8[7:0]) begin tests_failed++; $display("FAIL rand_dout8 job %0d got %h want %h", n, obs_dout8, e8[7:0]); end
            tests_run++; if (obs_ovf8 !== eo8 || obs_v8 !== 1'b1) begin tests_failed++; $display("FAIL rand_ovf8 job %0d got %b/%b want %b/1", n, obs_ovf8, obs_v8, eo8); end
            tests_run++; if (obs_done_cnt != 1 || obs_timeout) begin tests_failed++; $display("FAIL rand_done job %0d got %0d timeout %0d want 1", n, obs_done_cnt, obs_timeout); end
            tests_run++; if (obs_lat != ((trip == 0) ? 0 : 1)) begin tests_failed++; $display("FAIL rand_latency job %0d got %0d want %0d", n, obs_lat, (trip == 0) ? 0 : 1); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_stall_backpressure();
        test_zero_trip();
        test_overflow();
        test_start_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
